agri_ctrl_core: RTL and testbench
=================================

// Module: agri_ctrl_core
// PURPOSE
// - Irrigation control core. Combines three sub-blocks:
//   - startup sequencer (ex Init_FSM);
//   - 4-bit loadable down-counter timebase (ex ContLd);
//   - tank-level operation sequencer (ex Operation_FSM).
// - Sits beside the process FSM / temporiser. Receives the process run-permit O6. Supplies H1 (system ready) and RC (terminal count).
// PARAMETERS
// - W        4  counter width (Q, D).
// - TC_WRAP  F  value loaded on a down-count from 0 (all ones).
// PORTS
// - Ck     in   1  single clock; all state updates on the rising edge.
// - Clr    in   1  reset: synchronous, active-high.
// - Start  in   1  startup request (level, sampled in S_IDLE).
// - I1..I4 in   1  startup stage confirmations (I1 first).
// - I5     in   1  tank level HIGH sensor.
// - I6     in   1  tank level MID sensor.
// - I7     in   1  tank level LOW sensor.
// - O6     in   1  process run-permit from the process FSM.
// - CE     in   1  counter count enable.
// - Ld     in   1  counter synchronous load.
// - D      in   W  counter load value.
// - O1..O4 out  1  startup stage actuators (cumulative).
// - H1     out  1  system ready (startup complete).
// - O7     out  1  fill valve.
// - O8     out  1  irrigation outlet.
// - O9     out  1  sensor alarm.
// - Q      out  W  counter value.
// - RC     out  1  ripple/terminal count.
// BEHAVIOUR
// - Clr=1 at a Ck edge has priority over all other inputs. It forces:
//   - Init to S_IDLE;
//   - Op to OP_IDLE;
//   - Q=0.
// - Reset output values: O1..O4=0, H1=0, O7=O8=O9=0, Q=0.
//   RC=0 while CE=0.
// - Clr mid-operation aborts any sequence immediately. The next edge after Clr deasserts restarts from idle.
// - Init FSM (Moore, registered state):
//   - S_IDLE: Start=1 -> S1.
//   - S1: O1. I1=1 -> S2.
//   - S2: O1,O2. I2=1 -> S3.
//   - S3: O1..O3. I3=1 -> S4.
//   - S4: O1..O4. I4=1 -> S_RDY.
//   - S_RDY: O1..O4, H1=1. Held until Clr (Start ignored).
//   - One stage per edge max. A confirmation already high advances on the next edge.
//   - Confirmations for later stages are ignored until their stage is reached.
// - Counter (registered Q):
//   - Priority: Clr > Ld > CE.
//   - Ld=1: Q<=D (regardless of CE).
//   - CE=1, Ld=0: Q<=Q-1; from 0, Q<=TC_WRAP.
//   - Otherwise Q holds.
//   - RC = CE & (Q==0), combinational, valid the same cycle.
// - Operation FSM (Moore):
//   - OP_IDLE: no outputs.
//     - H1 & O6 -> I5 ? OP_IRR : OP_FILL.
//   - OP_FILL: O7=1. I5=1 -> OP_IRR.
//   - OP_IRR: O8=1. I7=0 -> OP_FILL.
//   - From OP_FILL or OP_IRR: H1=0 or O6=0 -> OP_IDLE (checked before the other transitions).
//   - O7 and O8 are never both 1.
// - Alarm O9: registered. Next value = (I5 & ~I6) | (I6 & ~I7) | (I5 & ~I7), i.e. non-monotonic levels.
//   - Evaluated in every state, including OP_IDLE.
//   - One-cycle latency.
// - All outputs except RC come directly from registers. No combinational input-to-output path except RC.
// CONFIGURATION
// - AGRI_ALARM_EN defined: O9 behaves as above.
// - Not defined: O9 tied 0. The alarm logic is removed; FSM behaviour is unchanged.
// TESTING
// - Clr=1 for 2 edges -> all outputs 0, Q=0.
//   Then Start=1 for 1 edge -> O1=1 on that edge.
// - I1..I4 raised on successive edges 2 apart -> O1, O1O2, O1..O3, O1..O4 build up, then H1=1.
//   H1 holds with Start=0. I2 before I1 -> no advance.
// - D=4'hC, Ld=1 one edge -> Q=C.
//   Then CE=1 -> B, A, ... 1, 0 (RC=1 while Q=0 & CE), then F.
//   Ld&CE with D=8 -> Q=8.
// - H1=1, O6=1, levels 0 -> O7=1.
//   Raise I7, I6, I5 -> O8=1, O7=0.
//   Drop I5, I6 -> O8 stays. Drop I7 -> O7=1.
//   O6=0 -> OP_IDLE, outputs 0.
// - AGRI_ALARM_EN: I5=1, I6=0 -> O9=1 one edge later; I6=1, I7=1 -> O9=0.
//   Without macro -> O9 stays 0.
// - Clr asserted in S3 and OP_FILL -> next edge: all outputs 0, and Start is required again.

Source files
------------

// File: rtl/agri_ctrl_core.sv
// -----------------------------------------------------------------------------
// agri_ctrl_core
//   Irrigation control core. Three cooperating blocks share one clock:
//     - startup sequencer : S_IDLE -> S1..S4 -> S_RDY, builds up O1..O4, then H1
//     - timebase counter  : W-bit loadable down-counter, Q / RC
//     - operation FSM     : tank-level fill / irrigate sequencing (O7 / O8)
//   plus an optional level-sensor plausibility alarm (O9).
//
// Build option
//   AGRI_ALARM_EN : when defined, O9 flags non-monotonic tank level readings
//                   (one cycle late). When undefined, O9 is tied low and the
//                   alarm logic is not built.
//
// Ports
//   Ck        clock, everything updates on the rising edge
//   Clr       synchronous active-high reset, beats every other input
//   Start     startup request, only looked at in S_IDLE
//   I1..I4    startup stage confirmations
//   I5/I6/I7  tank level HIGH / MID / LOW sensors
//   O6        process run-permit
//   CE/Ld/D   counter enable / load / load value
//   O1..O4    cumulative startup stage actuators
//   H1        system ready
//   O7/O8     fill valve / irrigation outlet
//   O9        sensor alarm
//   Q/RC      counter value / terminal count (RC is the only combinational out)
// -----------------------------------------------------------------------------
module agri_ctrl_core #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  TC_WRAP = '1
) (
  input  logic         Ck,
  input  logic         Clr,
  input  logic         Start,
  input  logic         I1,
  input  logic         I2,
  input  logic         I3,
  input  logic         I4,
  input  logic         I5,
  input  logic         I6,
  input  logic         I7,
  input  logic         O6,
  input  logic         CE,
  input  logic         Ld,
  input  logic [W-1:0] D,
  output logic         O1,
  output logic         O2,
  output logic         O3,
  output logic         O4,
  output logic         H1,
  output logic         O7,
  output logic         O8,
  output logic         O9,
  output logic [W-1:0] Q,
  output logic         RC
);

  typedef enum logic [2:0] {S_IDLE, S1, S2, S3, S4, S_RDY} init_e;
  typedef enum logic [1:0] {OP_IDLE, OP_FILL, OP_IRR}       op_e;

  init_e        init_q, init_d;
  op_e          op_q,   op_d;
  logic [W-1:0] cnt_q,  cnt_d;
  logic [3:0]   stg_q,  stg_d;   // stg[0]=O1 .. stg[3]=O4
  logic         h1_q,   h1_d;
  logic         o7_q,   o7_d;
  logic         o8_q,   o8_d;

  // ---------------------------------------------------------------------------
  // Startup sequencer: one stage per edge, each stage only listens to its own
  // confirmation, so early confirmations of later stages are simply ignored.
  // ---------------------------------------------------------------------------
  always_comb begin
    init_d = init_q;
    case (init_q)
      S_IDLE:  if (Start) init_d = S1;
      S1:      if (I1)    init_d = S2;
      S2:      if (I2)    init_d = S3;
      S3:      if (I3)    init_d = S4;
      S4:      if (I4)    init_d = S_RDY;
      S_RDY:              init_d = S_RDY;
      default:            init_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change on
  // the same edge the state does but never glitch from the inputs.
  always_comb begin
    stg_d = 4'b0000;
    case (init_d)
      S1:           stg_d = 4'b0001;
      S2:           stg_d = 4'b0011;
      S3:           stg_d = 4'b0111;
      S4, S_RDY:    stg_d = 4'b1111;
      default:      stg_d = 4'b0000;
    endcase
    h1_d = (init_d == S_RDY);
  end

  // ---------------------------------------------------------------------------
  // Operation FSM. Loss of ready or run-permit wins over level transitions.
  // Uses the registered H1, i.e. the ready flag the outside world sees.
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d = op_q;
    case (op_q)
      OP_IDLE: if (h1_q && O6) op_d = I5 ? OP_IRR : OP_FILL;
      OP_FILL: begin
        if (!h1_q || !O6) op_d = OP_IDLE;
        else if (I5)      op_d = OP_IRR;
      end
      OP_IRR: begin
        if (!h1_q || !O6) op_d = OP_IDLE;
        else if (!I7)     op_d = OP_FILL;
      end
      default: op_d = OP_IDLE;
    endcase
    // One-hot state decode keeps fill and outlet mutually exclusive.
    o7_d = (op_d == OP_FILL);
    o8_d = (op_d == OP_IRR);
  end

  // ---------------------------------------------------------------------------
  // Timebase counter: load beats count; counting down from 0 wraps to TC_WRAP.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (Ld)
      cnt_d = D;
    else if (CE)
      cnt_d = (cnt_q == '0) ? TC_WRAP : cnt_q - W'(1);
  end

  always_ff @(posedge Ck) begin
    if (Clr) begin
      init_q <= S_IDLE;
      op_q   <= OP_IDLE;
      cnt_q  <= '0;
      stg_q  <= 4'b0000;
      h1_q   <= 1'b0;
      o7_q   <= 1'b0;
      o8_q   <= 1'b0;
    end else begin
      init_q <= init_d;
      op_q   <= op_d;
      cnt_q  <= cnt_d;
      stg_q  <= stg_d;
      h1_q   <= h1_d;
      o7_q   <= o7_d;
      o8_q   <= o8_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Level-sensor alarm: a healthy tank reads LOW <= MID <= HIGH, so any higher
  // sensor wet while a lower one is dry means a faulty sensor.
  // ---------------------------------------------------------------------------
`ifdef AGRI_ALARM_EN
  logic o9_q, o9_d;

  always_comb begin
    o9_d = (I5 & ~I6) | (I6 & ~I7) | (I5 & ~I7);
  end

  always_ff @(posedge Ck) begin
    if (Clr) o9_q <= 1'b0;
    else     o9_q <= o9_d;
  end

  assign O9 = o9_q;
`else
  logic unused_alarm_in;
  assign unused_alarm_in = I6;
  assign O9 = 1'b0;
`endif

  assign {O4, O3, O2, O1} = stg_q;
  assign H1 = h1_q;
  assign O7 = o7_q;
  assign O8 = o8_q;
  assign Q  = cnt_q;
  // Terminal count is deliberately combinational so it lines up with Q.
  assign RC = CE & (cnt_q == '0);

endmodule

// File: tb/tb_agri_ctrl_core.sv
module tb_agri_ctrl_core;

  logic       Ck = 1'b0;
  logic       Clr = 1'b1, Start = 1'b0;
  logic       I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0;
  logic       I5 = 1'b0, I6 = 1'b0, I7 = 1'b0, O6 = 1'b0;
  logic       CE = 1'b0, Ld = 1'b0;
  logic [3:0] D = 4'h0;
  logic       O1, O2, O3, O4, H1, O7, O8, O9, RC;
  logic [3:0] Q;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    string      tag;
    logic [7:0] o;    // {O1,O2,O3,O4,H1,O7,O8,O9}
    logic [3:0] q;
    logic       rc;
  } exp_t;

  exp_t sb[$];

  agri_ctrl_core dut (
    .Ck(Ck), .Clr(Clr), .Start(Start),
    .I1(I1), .I2(I2), .I3(I3), .I4(I4),
    .I5(I5), .I6(I6), .I7(I7), .O6(O6),
    .CE(CE), .Ld(Ld), .D(D),
    .O1(O1), .O2(O2), .O3(O3), .O4(O4), .H1(H1),
    .O7(O7), .O8(O8), .O9(O9), .Q(Q), .RC(RC)
  );

  always #5 Ck = ~Ck;

  always @(posedge Ck) begin
    cyc <= cyc + 1;
    if (cyc > 2000) begin
      $display("FAIL timeout act=%0d cycles exp<=2000", cyc);
      $fatal(1, "timeout");
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Push the expected post-edge outputs, clock once, then pop and compare
  // on the falling edge while inputs are still stable.
  task automatic tick(input string tag, input logic [7:0] o, input logic [3:0] q, input logic rc);
    exp_t e;
    e.tag = tag; e.o = o; e.q = q; e.rc = rc;
`ifndef AGRI_ALARM_EN
    e.o[0] = 1'b0;
`endif
    sb.push_back(e);
    @(posedge Ck);
    @(negedge Ck);
    e = sb.pop_front();
    chk({e.tag, "_out"}, {24'd0, O1, O2, O3, O4, H1, O7, O8, O9}, {24'd0, e.o});
    chk({e.tag, "_q"},   {28'd0, Q},  {28'd0, e.q});
    chk({e.tag, "_rc"},  {31'd0, RC}, {31'd0, e.rc});
  endtask

  initial begin
    @(negedge Ck);
    // reset
    tick("rst0", 8'b0000_0000, 4'h0, 1'b0);
    tick("rst1", 8'b0000_0000, 4'h0, 1'b0);
    Clr = 1'b0; Start = 1'b1;
    tick("start", 8'b1000_0000, 4'h0, 1'b0);
    Start = 1'b0;
    // startup sequence
    I2 = 1'b1;
    tick("i2_early", 8'b1000_0000, 4'h0, 1'b0);
    I1 = 1'b1;
    tick("s2", 8'b1100_0000, 4'h0, 1'b0);
    tick("s3_prehigh", 8'b1110_0000, 4'h0, 1'b0);
    I1 = 1'b0; I2 = 1'b0;
    tick("s3_hold", 8'b1110_0000, 4'h0, 1'b0);
    I3 = 1'b1;
    tick("s4", 8'b1111_0000, 4'h0, 1'b0);
    I3 = 1'b0;
    tick("s4_hold", 8'b1111_0000, 4'h0, 1'b0);
    I4 = 1'b1;
    tick("rdy", 8'b1111_1000, 4'h0, 1'b0);
    I4 = 1'b0;
    tick("rdy_hold", 8'b1111_1000, 4'h0, 1'b0);
    Start = 1'b1;
    tick("rdy_start", 8'b1111_1000, 4'h0, 1'b0);
    Start = 1'b0;
    // operation
    O6 = 1'b1;
    tick("op_fill", 8'b1111_1100, 4'h0, 1'b0);
    tick("op_fill2", 8'b1111_1100, 4'h0, 1'b0);
    I7 = 1'b1;
    tick("fill_i7", 8'b1111_1100, 4'h0, 1'b0);
    I6 = 1'b1;
    tick("fill_i6", 8'b1111_1100, 4'h0, 1'b0);
    I5 = 1'b1;
    tick("irr", 8'b1111_1010, 4'h0, 1'b0);
    I5 = 1'b0;
    tick("irr_no5", 8'b1111_1010, 4'h0, 1'b0);
    I6 = 1'b0;
    tick("irr_no6", 8'b1111_1010, 4'h0, 1'b0);
    I7 = 1'b0;
    tick("refill", 8'b1111_1100, 4'h0, 1'b0);
    O6 = 1'b0;
    tick("op_idle", 8'b1111_1000, 4'h0, 1'b0);
    // alarm
    I5 = 1'b1;
    tick("alarm_on", 8'b1111_1001, 4'h0, 1'b0);
    I6 = 1'b1; I7 = 1'b1;
    tick("alarm_off", 8'b1111_1000, 4'h0, 1'b0);
    O6 = 1'b1;
    tick("idle_to_irr", 8'b1111_1010, 4'h0, 1'b0);
    O6 = 1'b0;
    tick("irr_to_idle", 8'b1111_1000, 4'h0, 1'b0);
    I5 = 1'b0; I6 = 1'b0; I7 = 1'b0;
    // counter
    D = 4'hC; Ld = 1'b1;
    tick("ld_c", 8'b1111_1000, 4'hC, 1'b0);
    Ld = 1'b0; CE = 1'b1;
    for (int v = 11; v >= 0; v--) begin
      logic [3:0] ev;
      ev = v[3:0];
      tick("cnt_dn", 8'b1111_1000, ev, (v == 0));
    end
    tick("cnt_wrap", 8'b1111_1000, 4'hF, 1'b0);
    D = 4'h8; Ld = 1'b1;
    tick("ld_ce", 8'b1111_1000, 4'h8, 1'b0);
    Ld = 1'b0; CE = 1'b0;
    tick("cnt_hold", 8'b1111_1000, 4'h8, 1'b0);
    // Clr from ready, restart needs Start
    Clr = 1'b1;
    tick("clr_rdy", 8'b0000_0000, 4'h0, 1'b0);
    Clr = 1'b0;
    tick("no_start", 8'b0000_0000, 4'h0, 1'b0);
    Start = 1'b1;
    tick("restart", 8'b1000_0000, 4'h0, 1'b0);
    Start = 1'b0; I1 = 1'b1;
    tick("re_s2", 8'b1100_0000, 4'h0, 1'b0);
    I1 = 1'b0; I2 = 1'b1;
    tick("re_s3", 8'b1110_0000, 4'h0, 1'b0);
    I2 = 1'b0; Clr = 1'b1;
    tick("clr_s3", 8'b0000_0000, 4'h0, 1'b0);
    Clr = 1'b0; I3 = 1'b1;
    tick("after_clr_s3", 8'b0000_0000, 4'h0, 1'b0);
    // all confirmations held high: still one stage per edge
    Start = 1'b1; I1 = 1'b1; I2 = 1'b1; I4 = 1'b1;
    tick("b_s1", 8'b1000_0000, 4'h0, 1'b0);
    Start = 1'b0;
    tick("b_s2", 8'b1100_0000, 4'h0, 1'b0);
    tick("b_s3", 8'b1110_0000, 4'h0, 1'b0);
    tick("b_s4", 8'b1111_0000, 4'h0, 1'b0);
    tick("b_rdy", 8'b1111_1000, 4'h0, 1'b0);
    I1 = 1'b0; I2 = 1'b0; I3 = 1'b0; I4 = 1'b0;
    O6 = 1'b1;
    tick("b_fill", 8'b1111_1100, 4'h0, 1'b0);
    // Clr in OP_FILL, also beating a pending load
    Clr = 1'b1; Ld = 1'b1; D = 4'h5;
    tick("clr_fill", 8'b0000_0000, 4'h0, 1'b0);
    Clr = 1'b0; Ld = 1'b0;
    tick("after_clr_fill", 8'b0000_0000, 4'h0, 1'b0);
    // RC follows CE combinationally at Q==0
    CE = 1'b1; Ld = 1'b1; D = 4'h0;
    tick("rc_ld0", 8'b0000_0000, 4'h0, 1'b1);
    CE = 1'b0; Ld = 1'b0;
    tick("rc_ce0", 8'b0000_0000, 4'h0, 1'b0);

    if (sb.size() != 0) chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
